// File: rtl/mem_write_buffer.sv
// Write-through store buffer with read-conflict draining; WB_COALESCE_EN merges stores into queued non-head entries.
// Memory request one cycle after IDLE arbitration, rd_valid one cycle after mem_ready; push_ready drops when full (no bypass).
module mem_write_buffer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;

  logic              full;
  logic              push_fire;
  logic              alloc;
  logic              pop;
  logic              conflict;
  logic              coal_hit;
  logic              coal_fire;
  logic [PW-1:0]     coal_idx;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push_ready = !full;
  assign push_fire  = push_valid && !full;
  assign pop        = (state == WR_BUSY) && mem_ready;
  assign alloc      = push_fire && !coal_hit;
  assign coal_fire  = push_fire && coal_hit;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i][ADDR_W-1:2] == rd_addr[ADDR_W-1:2]))
        conflict = 1'b1;
    end
  end

`ifdef WB_COALESCE_EN
  // The head is excluded: it may already be on the memory bus.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (PW'(i) != rd_ptr) &&
          (ent_addr[i][ADDR_W-1:2] == push_addr[ADDR_W-1:2])) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end else if (coal_fire) begin
      ent_data[coal_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (alloc) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // rd_valid high means the held rd_req was just answered; do not reissue it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req && !rd_valid && !conflict) begin
            state     <= RD_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= rd_addr;
            mem_wdata <= '0;
          end else if (!empty) begin
            state     <= WR_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= ent_addr[rd_ptr];
            mem_wdata <= ent_data[rd_ptr];
          end
        end
        WR_BUSY: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        RD_BUSY: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            rd_valid <= 1'b1;
            rd_data  <= mem_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter DEPTH, default 4, FIFO entries; a power of 2, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 push_valid  input  1  cache presents a write-through store.
REQ-007 push_ready  output  1  buffer accepts a store this cycle.
REQ-008 push_addr, push_data  input  ADDR_W, DATA_W  store address and data.
REQ-009 rd_req  input  1  refill word read; held high until rd_valid.
REQ-010 rd_addr  input  ADDR_W  refill read address; stable while rd_req is high.
REQ-011 rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-012 rd_data  output  DATA_W  read data.
REQ-013 mem_req, mem_we  output  1, 1  memory request and write strobe.
REQ-014 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-015 mem_ready  input  1  one-cycle memory completion pulse; mem_rdata is valid on reads.
REQ-016 mem_rdata  input  DATA_W  memory read data.
REQ-017 empty, count  output  1, $clog2(DEPTH)+1  occupancy status.

Function
REQ-018 A store is accepted on a rising edge where push_valid and push_ready are both high; push_ready equals !full.
- No same-cycle bypass: a full buffer rejects the store even if a drain completes in that cycle.
REQ-019 FSM states: IDLE, WR_BUSY, RD_BUSY.
- From IDLE, mem_req is raised in the cycle after the arbitration decision.
- mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready.
REQ-020 IDLE arbitration order:
- (a) rd_req with no read conflict -> RD_BUSY.
- (b) not empty -> WR_BUSY, issuing the head entry.
- (c) otherwise remain in IDLE.
REQ-021 Read conflict: any valid entry whose word address (addr[ADDR_W-1:2]) equals rd_addr[ADDR_W-1:2].
- While a conflict exists, the buffer drains entries in FIFO order and does not issue the read.
REQ-022 WR_BUSY + mem_ready: pop the head, decrement count, go to IDLE.
REQ-023 RD_BUSY + mem_ready: go to IDLE, and in the same edge drive rd_valid=1 with rd_data=mem_rdata for exactly one cycle.
REQ-024 Simultaneous push and pop in the same cycle leaves count unchanged.
- Read and write pointers wrap modulo DEPTH.
REQ-025 mem_ready arriving in IDLE is ignored.
REQ-026 rd_req is not sampled while the FSM is in RD_BUSY or WR_BUSY.
- Minimum read latency with no conflict: rd_valid is asserted 1 cycle after mem_ready.

Reset
REQ-027 On rst=1 at a rising edge: FSM to IDLE; pointers and count to 0; all entry valid bits cleared.
REQ-028 Outputs after reset: mem_req=0, mem_we=0, rd_valid=0, empty=1, push_ready=1, count=0; mem_addr, mem_wdata and rd_data are 0.
REQ-029 Reset mid-transaction discards the in-flight request and all queued stores; no mem_req or rd_valid follows.

Configuration
REQ-030 Macro WB_COALESCE_EN, when defined: a push whose word address matches a valid entry other than the head overwrites that entry's data in place.
- count is unchanged by a coalesced push.
- A push matching the head while in WR_BUSY allocates a new entry.
- Not defined: every accepted push allocates a new entry.

Verification
REQ-031 Memory model: initialised with data = address; mem_ready returned 3 cycles after mem_req.
- Read 0x0008 with buffer empty -> one read on memory, rd_valid with rd_data=0x00000008, zero writes.
REQ-032 Push 0x0008/0xAABBCCDD, then rd_req 0x0008 -> the write completes first, then the read returns 0xAABBCCDD.
REQ-033 Push 4 stores to 0x0100, 0x0104, 0x0108, 0x010C -> push_ready=0, count=4, and the 5th push stalls.
- The entries drain in order, and empty=1 after the 4th mem_ready.
REQ-034 Push 0x0200 and 0x0204, then rd_req 0x0040 (no conflict) -> read issued before the 2nd write, rd_data=0x00000040.
REQ-035 With WB_COALESCE_EN: push 0x0300/0x11, then 0x0304/0x22, then 0x0304/0x33 -> count=2 and the memory writes are 0x11 then 0x33.
- Without the macro: count=3, three writes.
REQ-036 Assert rst while in WR_BUSY with 3 entries queued -> next cycle: empty=1 and mem_req=0, and no further memory writes.
